idu_pipe: RTL and testbench

- Registered instruction-decode stage for the NPC core. Sits between IFU and EXU, with valid/ready handshakes on both sides.
- Generalises the combinational decoder in three ways:
  - XLEN-parametrised: RV32I or RV64I, including the RV64 W-ops.
  - Optional M extension.
  - Precise illegal-instruction flagging instead of a sim-only `$finish`.
- Includes a 2-entry skid buffer so it sustains 1 instr/cycle under back-pressure, plus a flush input for branch redirect.

---
 rtl/idu_pkg.sv | 59 +++++
 rtl/idu_dec_comb.sv | 158 +++++++++++++++
 rtl/idu_pipe.sv | 127 ++++++++++++
 tb/tb_idu_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared opcode, function and op-code constants for the decode stage
package idu_pkg;
  localparam int EXU_OPT_WIDTH = 5;
  localparam int EXU_SEL_WIDTH = 2;
  localparam int LSU_OPT_WIDTH = 4;

  localparam logic [6:0] TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] TYPE_AUIPC = 7'b0010111;
  localparam logic [6:0] TYPE_JAL   = 7'b1101111;
  localparam logic [6:0] TYPE_JALR  = 7'b1100111;
  localparam logic [6:0] TYPE_B     = 7'b1100011;
  localparam logic [6:0] TYPE_L     = 7'b0000011;
  localparam logic [6:0] TYPE_S     = 7'b0100011;
  localparam logic [6:0] TYPE_I     = 7'b0010011;
  localparam logic [6:0] TYPE_R     = 7'b0110011;
  localparam logic [6:0] TYPE_I_W   = 7'b0011011;
  localparam logic [6:0] TYPE_R_W   = 7'b0111011;
  localparam logic [6:0] TYPE_FENCE = 7'b0001111;
  localparam logic [6:0] TYPE_SYS   = 7'b1110011;

  localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNC3_SLL     = 3'b001;
  localparam logic [2:0] FUNC3_SRL_SRA = 3'b101;
  localparam logic [6:0] FUNC7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV  = 7'b0000001;

  // ALU ops 0..7 follow func3 order so OP/OP-IMM can use func3 directly
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_ADD = 5'd0, EXU_SLL = 5'd1, EXU_SLT = 5'd2,
    EXU_SLTU = 5'd3, EXU_XOR = 5'd4, EXU_SRL = 5'd5, EXU_OR = 5'd6, EXU_AND = 5'd7,
    EXU_SUB = 5'd8, EXU_SRA = 5'd9, EXU_BEQ = 5'd10, EXU_BNE = 5'd11, EXU_BLT = 5'd12,
    EXU_BGE = 5'd13, EXU_BLTU = 5'd14, EXU_BGEU = 5'd15, EXU_EBREAK = 5'd16,
    EXU_ECALL = 5'd17, EXU_MUL = 5'd18, EXU_MULH = 5'd19, EXU_MULHSU = 5'd20,
    EXU_MULHU = 5'd21, EXU_DIV = 5'd22, EXU_DIVU = 5'd23, EXU_REM = 5'd24, EXU_REMU = 5'd25;

  localparam logic [EXU_SEL_WIDTH-1:0] EXU_SEL_REG = 2'd0, EXU_SEL_IMM = 2'd1,
    EXU_SEL_PC4 = 2'd2, EXU_SEL_PCI = 2'd3;

  localparam logic [LSU_OPT_WIDTH-1:0] LSU_NOP = 4'b1111;

  typedef struct packed {
    logic [4:0]               rdid;
    logic [4:0]               rs1id;
    logic [4:0]               rs2id;
    logic                     rdwen;
    logic [EXU_SEL_WIDTH-1:0] exu_src_sel;
    logic [EXU_OPT_WIDTH-1:0] exu_opt;
    logic                     exu_word;
    logic [LSU_OPT_WIDTH-1:0] lsu_opt;
    logic                     brch;
    logic                     jal;
    logic                     jalr;
    logic                     illegal;
  } idu_ctrl_t;

  localparam idu_ctrl_t CTRL_RST = '{rdid: 5'd0, rs1id: 5'd0, rs2id: 5'd0, rdwen: 1'b0,
    exu_src_sel: EXU_SEL_IMM, exu_opt: EXU_ADD, exu_word: 1'b0, lsu_opt: LSU_NOP,
    brch: 1'b0, jal: 1'b0, jalr: 1'b0, illegal: 1'b0};
endpackage

// File: rtl/idu_dec_comb.sv
// rtl/idu_dec_comb.sv - combinational RV32I/RV64I(+M) decoder with illegal-instruction flag
module idu_dec_comb
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]     i_instr,
  output idu_ctrl_t       o_ctrl,
  output logic [XLEN-1:0] o_imm
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] imm32;
  logic        has_rd, has_rs1, has_rs2, is_w, ill, lo_ok, shift_base, shift_alt;

  always_comb begin
    opcode  = i_instr[6:0];
    func3   = i_instr[14:12];
    func7   = i_instr[31:25];
    imm32   = 32'd0;
    has_rd  = 1'b0;
    has_rs1 = 1'b0;
    has_rs2 = 1'b0;
    is_w    = 1'b0;
    ill     = 1'b0;
    o_ctrl  = CTRL_RST;
    // RV64 non-W shifts own imm[5]; RV32 and W shifts must keep it clear
    lo_ok      = (RV64 && opcode == TYPE_I) || !i_instr[25];
    shift_base = (i_instr[31:26] == 6'b000000) && lo_ok;
    shift_alt  = (i_instr[31:26] == 6'b010000) && lo_ok;
    case (opcode)
      TYPE_LUI: begin
        has_rd = 1'b1;
        imm32  = {i_instr[31:12], 12'd0};
      end
      TYPE_AUIPC: begin
        has_rd = 1'b1;
        imm32  = {i_instr[31:12], 12'd0};
        o_ctrl.exu_src_sel = EXU_SEL_PCI;
      end
      TYPE_JAL: begin
        has_rd = 1'b1;
        imm32  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_ctrl.exu_src_sel = EXU_SEL_PC4;
        o_ctrl.jal = 1'b1;
      end
      TYPE_JALR: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
        o_ctrl.exu_src_sel = EXU_SEL_PC4;
        o_ctrl.jalr = 1'b1;
        ill = (func3 != 3'b000);
      end
      TYPE_B: begin
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_ctrl.exu_src_sel = EXU_SEL_REG;
        o_ctrl.brch = 1'b1;
        case (func3)
          3'b000:  o_ctrl.exu_opt = EXU_BEQ;
          3'b001:  o_ctrl.exu_opt = EXU_BNE;
          3'b100:  o_ctrl.exu_opt = EXU_BLT;
          3'b101:  o_ctrl.exu_opt = EXU_BGE;
          3'b110:  o_ctrl.exu_opt = EXU_BLTU;
          3'b111:  o_ctrl.exu_opt = EXU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      TYPE_L: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
        o_ctrl.lsu_opt = {func3, 1'b0};
        ill = (func3 == 3'b111) || (!RV64 && (func3 == 3'b011 || func3 == 3'b110));
      end
      TYPE_S: begin
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_ctrl.lsu_opt = {func3, 1'b1};
        ill = func3[2] || (!RV64 && func3 == 3'b011);
      end
      TYPE_I, TYPE_I_W: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        is_w    = (opcode == TYPE_I_W);
        imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
        ill     = is_w && !RV64;
        case (func3)
          FUNC3_SLL: begin
            o_ctrl.exu_opt = EXU_SLL;
            if (!shift_base) ill = 1'b1;
          end
          FUNC3_SRL_SRA: begin
            o_ctrl.exu_opt = shift_alt ? EXU_SRA : EXU_SRL;
            if (!(shift_base || shift_alt)) ill = 1'b1;
          end
          default: begin
            o_ctrl.exu_opt = EXU_OPT_WIDTH'(func3);
            if (is_w && func3 != FUNC3_ADD_SUB) ill = 1'b1;
          end
        endcase
      end
      TYPE_R, TYPE_R_W: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        is_w    = (opcode == TYPE_R_W);
        ill     = is_w && !RV64;
        o_ctrl.exu_src_sel = EXU_SEL_REG;
        case (func7)
          FUNC7_MULDIV: begin
            o_ctrl.exu_opt = EXU_MUL + EXU_OPT_WIDTH'(func3);
            if (!EN_M || (is_w && func3 != 3'b000 && !func3[2])) ill = 1'b1;
          end
          FUNC7_BASE: begin
            o_ctrl.exu_opt = EXU_OPT_WIDTH'(func3);
            if (is_w && !(func3 == FUNC3_ADD_SUB || func3 == FUNC3_SLL || func3 == FUNC3_SRL_SRA))
              ill = 1'b1;
          end
          FUNC7_ALT: begin
            if (func3 == FUNC3_ADD_SUB) o_ctrl.exu_opt = EXU_SUB;
            else if (func3 == FUNC3_SRL_SRA) o_ctrl.exu_opt = EXU_SRA;
            else ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      TYPE_FENCE: ill = (func3 != 3'b000);
      TYPE_SYS: begin
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        if (i_instr == 32'h0000_0073) o_ctrl.exu_opt = EXU_ECALL;
        else if (i_instr == 32'h0010_0073) o_ctrl.exu_opt = EXU_EBREAK;
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    o_ctrl.rdid     = has_rd  ? i_instr[11:7]  : 5'd0;
    o_ctrl.rs1id    = has_rs1 ? i_instr[19:15] : 5'd0;
    o_ctrl.rs2id    = has_rs2 ? i_instr[24:20] : 5'd0;
    o_ctrl.rdwen    = has_rd && (i_instr[11:7] != 5'd0) && !ill;
    o_ctrl.exu_word = is_w && !ill;
    o_ctrl.illegal  = ill;
    if (ill) begin
      o_ctrl.lsu_opt = LSU_NOP;
      o_ctrl.brch    = 1'b0;
      o_ctrl.jal     = 1'b0;
      o_ctrl.jalr    = 1'b0;
    end
    o_imm = XLEN'(signed'(imm32));
  end
endmodule

// File: rtl/idu_pipe.sv
// rtl/idu_pipe.sv - registered decode stage with 2-entry skid buffer and flush
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0,
  parameter int PC_W = XLEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_pre_valid,
  output logic                     o_pre_ready,
  input  logic [31:0]              i_instr,
  input  logic [PC_W-1:0]          i_pc,
  output logic                     o_post_valid,
  input  logic                     i_post_ready,
  output logic [PC_W-1:0]          o_pc,
  output logic [4:0]               o_rdid,
  output logic [4:0]               o_rs1id,
  output logic [4:0]               o_rs2id,
  output logic                     o_rdwen,
  output logic [XLEN-1:0]          o_imm,
  output logic [EXU_SEL_WIDTH-1:0] o_exu_src_sel,
  output logic [EXU_OPT_WIDTH-1:0] o_exu_opt,
  output logic                     o_exu_word,
  output logic [LSU_OPT_WIDTH-1:0] o_lsu_opt,
  output logic                     o_brch,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_illegal
);
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e          state_q, state_d;
  idu_ctrl_t       dec_ctrl, out_ctrl_q, out_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0] dec_imm, out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  logic            acc, deq;

  idu_dec_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .i_instr (i_instr),
    .o_ctrl  (dec_ctrl),
    .o_imm   (dec_imm)
  );

  // Ready depends on registered state only, never on i_post_ready
  assign o_pre_ready  = (state_q != ST_TWO);
  assign o_post_valid = (state_q != ST_EMPTY);
  assign acc = i_pre_valid && o_pre_ready;
  assign deq = o_post_valid && i_post_ready;

  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_imm_d  = skid_imm_q;
    skid_pc_d   = skid_pc_q;
    case (state_q)
      ST_EMPTY: if (acc) begin
        out_ctrl_d = dec_ctrl;
        out_imm_d  = dec_imm;
        out_pc_d   = i_pc;
        state_d    = ST_ONE;
      end
      ST_ONE: begin
        if (acc && deq) begin
          out_ctrl_d = dec_ctrl;
          out_imm_d  = dec_imm;
          out_pc_d   = i_pc;
        end else if (acc) begin
          skid_ctrl_d = dec_ctrl;
          skid_imm_d  = dec_imm;
          skid_pc_d   = i_pc;
          state_d     = ST_TWO;
        end else if (deq) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (deq) begin
        out_ctrl_d = skid_ctrl_q;
        out_imm_d  = skid_imm_q;
        out_pc_d   = skid_pc_q;
        state_d    = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (i_flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      out_ctrl_q  <= CTRL_RST;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
      skid_ctrl_q <= CTRL_RST;
      skid_imm_q  <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_ctrl_q  <= out_ctrl_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_imm_q  <= skid_imm_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign o_pc          = out_pc_q;
  assign o_imm         = out_imm_q;
  assign o_rdid        = out_ctrl_q.rdid;
  assign o_rs1id       = out_ctrl_q.rs1id;
  assign o_rs2id       = out_ctrl_q.rs2id;
  assign o_rdwen       = out_ctrl_q.rdwen;
  assign o_exu_src_sel = out_ctrl_q.exu_src_sel;
  assign o_exu_opt     = out_ctrl_q.exu_opt;
  assign o_exu_word    = out_ctrl_q.exu_word;
  assign o_lsu_opt     = out_ctrl_q.lsu_opt;
  assign o_brch        = out_ctrl_q.brch;
  assign o_jal         = out_ctrl_q.jal;
  assign o_jalr        = out_ctrl_q.jalr;
  assign o_illegal     = out_ctrl_q.illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// tb/tb_idu_pipe.sv - directed checks of idu_pipe across RV32I, RV32IM and RV64IM builds
module tb_idu_pipe;
  import idu_pkg::*;

  typedef struct {
    int          cfg;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic        wen;
    logic [63:0] imm;
    logic [4:0]  opt;
    logic [1:0]  src;
    logic        word;
    logic [3:0]  lsu;
    logic        brch, jal, jalr, ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        pre_valid = 1'b0;
  logic        post_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [63:0] pc = 64'd0;
  int          n_pass = 0;
  int          n_total = 0;

  logic a_pre_ready, a_post_valid, a_rdwen, a_word, a_brch, a_jal, a_jalr, a_ill;
  logic b_pre_ready, b_post_valid, b_rdwen, b_word, b_brch, b_jal, b_jalr, b_ill;
  logic c_pre_ready, c_post_valid, c_rdwen, c_word, c_brch, c_jal, c_jalr, c_ill;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_opt, b_rd, b_rs1, b_rs2, b_opt, c_rd, c_rs1, c_rs2, c_opt;
  logic [1:0]  a_src, b_src, c_src;
  logic [3:0]  a_lsu, b_lsu, c_lsu;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [63:0] c_pc, c_imm;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .EN_M(1'b0)) u_rv32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_pre_valid(pre_valid),
    .o_pre_ready(a_pre_ready), .i_instr(instr), .i_pc(pc[31:0]), .o_post_valid(a_post_valid),
    .i_post_ready(post_ready), .o_pc(a_pc), .o_rdid(a_rd), .o_rs1id(a_rs1), .o_rs2id(a_rs2),
    .o_rdwen(a_rdwen), .o_imm(a_imm), .o_exu_src_sel(a_src), .o_exu_opt(a_opt),
    .o_exu_word(a_word), .o_lsu_opt(a_lsu), .o_brch(a_brch), .o_jal(a_jal), .o_jalr(a_jalr),
    .o_illegal(a_ill));

  idu_pipe #(.XLEN(32), .EN_M(1'b1)) u_rv32m (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_pre_valid(pre_valid),
    .o_pre_ready(b_pre_ready), .i_instr(instr), .i_pc(pc[31:0]), .o_post_valid(b_post_valid),
    .i_post_ready(post_ready), .o_pc(b_pc), .o_rdid(b_rd), .o_rs1id(b_rs1), .o_rs2id(b_rs2),
    .o_rdwen(b_rdwen), .o_imm(b_imm), .o_exu_src_sel(b_src), .o_exu_opt(b_opt),
    .o_exu_word(b_word), .o_lsu_opt(b_lsu), .o_brch(b_brch), .o_jal(b_jal), .o_jalr(b_jalr),
    .o_illegal(b_ill));

  idu_pipe #(.XLEN(64), .EN_M(1'b1)) u_rv64m (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_pre_valid(pre_valid),
    .o_pre_ready(c_pre_ready), .i_instr(instr), .i_pc(pc), .o_post_valid(c_post_valid),
    .i_post_ready(post_ready), .o_pc(c_pc), .o_rdid(c_rd), .o_rs1id(c_rs1), .o_rs2id(c_rs2),
    .o_rdwen(c_rdwen), .o_imm(c_imm), .o_exu_src_sel(c_src), .o_exu_opt(c_opt),
    .o_exu_word(c_word), .o_lsu_opt(c_lsu), .o_brch(c_brch), .o_jal(c_jal), .o_jalr(c_jalr),
    .o_illegal(c_ill));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(int cfg, logic [31:0] ins, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic wen, logic [63:0] imm, logic [4:0] opt,
                              logic [1:0] src, logic word, logic [3:0] lsu, logic brch,
                              logic jal, logic jalr, logic ill);
    vec_t v;
    v.cfg = cfg; v.instr = ins; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.wen = wen;
    v.imm = imm; v.opt = opt; v.src = src; v.word = word; v.lsu = lsu;
    v.brch = brch; v.jal = jal; v.jalr = jalr; v.ill = ill;
    return v;
  endfunction

  task automatic observe(input int cfg, output vec_t o, output logic valid, output logic [63:0] opc);
    o.cfg = cfg; o.instr = instr;
    case (cfg)
      0: begin
        o.rd = a_rd; o.rs1 = a_rs1; o.rs2 = a_rs2; o.wen = a_rdwen; o.imm = {32'd0, a_imm};
        o.opt = a_opt; o.src = a_src; o.word = a_word; o.lsu = a_lsu; o.brch = a_brch;
        o.jal = a_jal; o.jalr = a_jalr; o.ill = a_ill; valid = a_post_valid; opc = {32'd0, a_pc};
      end
      1: begin
        o.rd = b_rd; o.rs1 = b_rs1; o.rs2 = b_rs2; o.wen = b_rdwen; o.imm = {32'd0, b_imm};
        o.opt = b_opt; o.src = b_src; o.word = b_word; o.lsu = b_lsu; o.brch = b_brch;
        o.jal = b_jal; o.jalr = b_jalr; o.ill = b_ill; valid = b_post_valid; opc = {32'd0, b_pc};
      end
      default: begin
        o.rd = c_rd; o.rs1 = c_rs1; o.rs2 = c_rs2; o.wen = c_rdwen; o.imm = c_imm;
        o.opt = c_opt; o.src = c_src; o.word = c_word; o.lsu = c_lsu; o.brch = c_brch;
        o.jal = c_jal; o.jalr = c_jalr; o.ill = c_ill; valid = c_post_valid; opc = c_pc;
      end
    endcase
  endtask

  function automatic logic [31:0] addi_x0(logic [4:0] rd);
    return {7'd0, rd, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  vec_t        vecs[$];
  vec_t        act;
  logic        act_valid;
  logic [63:0] act_pc;
  int          sent, recv;

  initial begin
    // cfg 0 = RV32I, 1 = RV32IM, 2 = RV64IM
    vecs.push_back(mk(0, 32'hFFF10093, 1, 2, 0, 1, 64'hFFFFFFFF, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h023100B3, 1, 2, 3, 0, 0, EXU_ADD, EXU_SEL_REG, 0, LSU_NOP, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h023100B3, 1, 2, 3, 1, 0, EXU_MUL, EXU_SEL_REG, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(2, 32'h003100BB, 1, 2, 3, 1, 0, EXU_ADD, EXU_SEL_REG, 1, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h003100BB, 1, 2, 3, 0, 0, EXU_ADD, EXU_SEL_REG, 0, LSU_NOP, 0, 0, 0, 1));
    vecs.push_back(mk(0, 32'h123452B7, 5, 0, 0, 1, 64'h12345000, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(2, 32'h800002B7, 5, 0, 0, 1, 64'hFFFFFFFF80000000, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'hFE208EE3, 0, 1, 2, 0, 64'hFFFFFFFC, EXU_BEQ, EXU_SEL_REG, 0, LSU_NOP, 1, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00822183, 3, 4, 0, 1, 64'h8, EXU_ADD, EXU_SEL_IMM, 0, 4'b0100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00532623, 0, 6, 5, 0, 64'hC, EXU_ADD, EXU_SEL_IMM, 0, 4'b0101, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h00013083, 1, 2, 0, 0, 0, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 1));
    vecs.push_back(mk(2, 32'h00013083, 1, 2, 0, 1, 0, EXU_ADD, EXU_SEL_IMM, 0, 4'b0110, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h40315093, 1, 2, 0, 1, 64'h403, EXU_SRA, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h02011093, 1, 2, 0, 0, 0, EXU_SLL, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 1));
    vecs.push_back(mk(2, 32'h02011093, 1, 2, 0, 1, 64'h20, EXU_SLL, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(2, 32'h42115093, 1, 2, 0, 1, 64'h421, EXU_SRA, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h008000EF, 1, 0, 0, 1, 64'h8, EXU_ADD, EXU_SEL_PC4, 0, LSU_NOP, 0, 1, 0, 0));
    vecs.push_back(mk(0, 32'h00100073, 0, 0, 0, 0, 64'h1, EXU_EBREAK, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 1));
    vecs.push_back(mk(0, 32'h00000013, 0, 0, 0, 0, 0, EXU_ADD, EXU_SEL_IMM, 0, LSU_NOP, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h403100B3, 1, 2, 3, 1, 0, EXU_SUB, EXU_SEL_REG, 0, LSU_NOP, 0, 0, 0, 0));

    // reset state
    step();
    step();
    chk("rst_post_valid", a_post_valid, 0);
    chk("rst_pre_ready", a_pre_ready, 1);
    chk("rst_opt", a_opt, EXU_ADD);
    chk("rst_src", a_src, EXU_SEL_IMM);
    chk("rst_lsu", a_lsu, LSU_NOP);
    chk("rst_rd", a_rd, 0);
    chk("rst_imm", c_imm, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_ill", a_ill, 0);
    rst_n = 1'b1;

    // decode table, streamed at one instruction per cycle
    post_ready = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      instr = vecs[k].instr;
      pc = 64'h1000 + 64'(k * 4);
      pre_valid = 1'b1;
      step();
      observe(vecs[k].cfg, act, act_valid, act_pc);
      chk($sformatf("v%0d_valid", k), act_valid, 1);
      chk($sformatf("v%0d_pc", k), act_pc, 64'h1000 + 64'(k * 4));
      chk($sformatf("v%0d_rd", k), act.rd, vecs[k].rd);
      chk($sformatf("v%0d_rs1", k), act.rs1, vecs[k].rs1);
      chk($sformatf("v%0d_rs2", k), act.rs2, vecs[k].rs2);
      chk($sformatf("v%0d_wen", k), act.wen, vecs[k].wen);
      chk($sformatf("v%0d_word", k), act.word, vecs[k].word);
      chk($sformatf("v%0d_lsu", k), act.lsu, vecs[k].lsu);
      chk($sformatf("v%0d_ctl", k), {act.brch, act.jal, act.jalr}, {vecs[k].brch, vecs[k].jal, vecs[k].jalr});
      chk($sformatf("v%0d_ill", k), act.ill, vecs[k].ill);
      if (!vecs[k].ill) begin
        chk($sformatf("v%0d_imm", k), act.imm, vecs[k].imm);
        chk($sformatf("v%0d_opt", k), act.opt, vecs[k].opt);
        chk($sformatf("v%0d_src", k), act.src, vecs[k].src);
      end
    end
    pre_valid = 1'b0;
    step();
    chk("drain_empty", a_post_valid, 0);

    // back-pressure: two accepts fill the buffer, outputs hold instr0
    post_ready = 1'b0;
    pre_valid = 1'b1;
    instr = addi_x0(5'd1);
    step();
    chk("bp_ready_after1", a_pre_ready, 1);
    instr = addi_x0(5'd2);
    step();
    chk("bp_ready_after2", a_pre_ready, 0);
    chk("bp_hold_rd", a_rd, 1);
    instr = addi_x0(5'd3);
    step();
    chk("bp_stable_rd", a_rd, 1);
    chk("bp_stable_imm", a_imm, 1);
    chk("bp_stable_valid", a_post_valid, 1);
    sent = 2;
    recv = 0;
    post_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      logic acc_now, deq_now;
      pre_valid = (sent < 4);
      instr = addi_x0(5'(sent + 1));
      acc_now = a_pre_ready && pre_valid;
      deq_now = a_post_valid;
      if (deq_now) begin
        chk($sformatf("bp_order%0d", recv), a_rd, 64'(recv + 1));
        recv++;
      end
      step();
      if (acc_now) sent++;
    end
    chk("bp_recv_count", recv, 4);
    chk("bp_no_dup", a_post_valid, 0);

    // flush while full, with a new instruction offered
    post_ready = 1'b0;
    pre_valid = 1'b1;
    instr = addi_x0(5'd1);
    step();
    step();
    flush = 1'b1;
    instr = addi_x0(5'd9);
    step();
    flush = 1'b0;
    pre_valid = 1'b0;
    chk("fl2_post_valid", a_post_valid, 0);
    chk("fl2_pre_ready", a_pre_ready, 1);
    post_ready = 1'b1;
    step();
    chk("fl2_no_ghost", a_post_valid, 0);

    // flush in ONE while the same cycle accepts: the accepted instr is dropped
    post_ready = 1'b0;
    pre_valid = 1'b1;
    instr = addi_x0(5'd1);
    step();
    flush = 1'b1;
    instr = addi_x0(5'd9);
    step();
    flush = 1'b0;
    pre_valid = 1'b0;
    chk("fl1_post_valid", a_post_valid, 0);
    step();
    chk("fl1_no_ghost", a_post_valid, 0);

    // synchronous reset while full
    pre_valid = 1'b1;
    instr = addi_x0(5'd1);
    step();
    instr = addi_x0(5'd2);
    step();
    pre_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("srst_async_valid", a_post_valid, 1);
    chk("srst_async_rd", a_rd, 1);
    step();
    chk("srst_valid", a_post_valid, 0);
    chk("srst_ready", a_pre_ready, 1);
    chk("srst_rd", a_rd, 0);
    chk("srst_imm", a_imm, 0);
    rst_n = 1'b1;
    post_ready = 1'b1;
    step();
    chk("srst_skid_gone", a_post_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
